pipeline_hazard_ctrl: RTL and testbench

//  Sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//  - Drives every latch enable/flush from icache/dcache ready, load-use hazards and
//    MEM-stage redirects (branch/jump/jr), and drains the pipe on halt.
//  - Keeps a saturating stall-cycle counter.
//  - One instance per core, between the decode/EX-MEM outputs and the latch interfaces.

---
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequences the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Latch enables and flushes are decoded combinationally from the current state and
// the hazard inputs. Only the state, the sticky halt flag and the saturating
// stall-cycle counter are registered.
// A flushed latch always has its enable high as well, so that it loads a bubble.

module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ihit_i,
    input  logic             dhit_i,
    input  logic             mem_req_i,
    input  logic             mem_redirect_i,
    input  logic             mem_halt_i,
    input  logic             idex_dren_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    output logic             pc_en_o,
    output logic             pc_sel_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_en_o,
    output logic             idex_flush_o,
    output logic             exmem_en_o,
    output logic             exmem_flush_o,
    output logic             memwb_en_o,
    output logic             memwb_flush_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic pc_sel;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic memwb_flush;
    } ctl_t;

    state_t           state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    ctl_t run_ctl;
    logic run_to_drain;
    ctl_t ctl;
    logic load_use;

    // A load in ID/EX whose destination feeds the instruction in IF/ID. Register 0 never creates a hazard.
    assign load_use = idex_dren_i && (idex_rt_i != '0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    // Normal-flow decode (halt > redirect > load-use > icache miss), shared by RUN and by DWAIT completion
    always_comb begin
        run_ctl      = '{pc_en: 1'b1, pc_sel: 1'b0,
                         ifid_en: 1'b1, ifid_flush: 1'b0,
                         idex_en: 1'b1, idex_flush: 1'b0,
                         exmem_en: 1'b1, exmem_flush: 1'b0,
                         memwb_en: 1'b1, memwb_flush: 1'b0};
        run_to_drain = 1'b0;
        if (mem_halt_i) begin
            run_ctl.pc_en       = 1'b0;
            run_ctl.ifid_flush  = 1'b1;
            run_ctl.idex_flush  = 1'b1;
            run_ctl.exmem_flush = 1'b1;
            run_to_drain        = 1'b1;
        end else if (mem_redirect_i) begin
            run_ctl.pc_sel      = 1'b1;
            run_ctl.ifid_flush  = 1'b1;
            run_ctl.idex_flush  = 1'b1;
            run_ctl.exmem_flush = 1'b1;
        end else if (load_use) begin
            run_ctl.pc_en      = 1'b0;
            run_ctl.ifid_en    = 1'b0;
            run_ctl.idex_flush = 1'b1;
        end else if (!ihit_i) begin
            run_ctl.pc_en      = 1'b0;
            run_ctl.ifid_flush = 1'b1;
        end
    end

    // State-dependent control selection and next-state logic; reset silences every control
    always_comb begin
        ctl     = '0;
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_req_i && !dhit_i) begin
                    state_d = DWAIT;
                end else begin
                    ctl     = run_ctl;
                    state_d = run_to_drain ? DRAIN : RUN;
                end
            end
            DWAIT: begin
                if (dhit_i) begin
                    ctl     = run_ctl;
                    state_d = run_to_drain ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                ctl.ifid_en     = 1'b1;
                ctl.ifid_flush  = 1'b1;
                ctl.idex_en     = 1'b1;
                ctl.idex_flush  = 1'b1;
                ctl.exmem_en    = 1'b1;
                ctl.exmem_flush = 1'b1;
                ctl.memwb_en    = 1'b1;
                state_d         = HALTED;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!rst_n) begin
            ctl = '0;
        end
    end

    // Next values for the sticky halt flag and the saturating stall counter
    always_comb begin
        halt_d      = (state_d == HALTED);
        stall_cnt_d = stall_cnt_q;
        if ((state_q != HALTED) && !ctl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, halt flag and stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_en_o       = ctl.pc_en;
    assign pc_sel_o      = ctl.pc_sel;
    assign ifid_en_o     = ctl.ifid_en;
    assign ifid_flush_o  = ctl.ifid_flush;
    assign idex_en_o     = ctl.idex_en;
    assign idex_flush_o  = ctl.idex_flush;
    assign exmem_en_o    = ctl.exmem_en;
    assign exmem_flush_o = ctl.exmem_flush;
    assign memwb_en_o    = ctl.memwb_en;
    assign memwb_flush_o = ctl.memwb_flush;
    assign halt_o        = halt_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. A 16-bit counter instance and a 4-bit
// counter instance share the same stimulus. Each step pushes its expected controls and
// counts onto a scoreboard. The entry is then popped and compared on the falling edge.

module tb_pipeline_hazard_ctrl;

    // Expected control vector order: pc_en pc_sel ifid(en,fl) idex(en,fl) exmem(en,fl) memwb(en,fl)
    localparam logic [9:0] ZERO     = 10'b00_00_00_00_00;
    localparam logic [9:0] ALL_EN   = 10'b10_10_10_10_10;
    localparam logic [9:0] LOADUSE  = 10'b00_00_11_10_10;
    localparam logic [9:0] NOIHIT   = 10'b00_11_10_10_10;
    localparam logic [9:0] REDIRECT = 10'b11_11_11_11_10;
    localparam logic [9:0] HALTFL   = 10'b00_11_11_11_10;

    typedef struct packed {
        logic [9:0]  ctl;
        logic        halt;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic clk = 1'b0;
    logic rstN, ihit, dhit, memReq, memRedirect, memHalt, idexDren;
    logic [4:0] idexRt, ifidRs, ifidRt;

    logic pcEn, pcSel, ifidEn, ifidFlush, idexEn, idexFlush;
    logic exmemEn, exmemFlush, memwbEn, memwbFlush, haltOut;
    logic [15:0] stallCnt;

    logic pcEn4, pcSel4, ifidEn4, ifidFlush4, idexEn4, idexFlush4;
    logic exmemEn4, exmemFlush4, memwbEn4, memwbFlush4, haltOut4;
    logic [3:0] stallCnt4;

    logic [9:0] obsCtl, obsCtl4;

    exp_t  expQ[$];
    string tagQ[$];
    int checks = 0;
    int errors = 0;
    logic [15:0] expCnt  = '0;
    logic [3:0]  expCnt4 = '0;

    assign obsCtl  = {pcEn, pcSel, ifidEn, ifidFlush, idexEn, idexFlush,
                      exmemEn, exmemFlush, memwbEn, memwbFlush};
    assign obsCtl4 = {pcEn4, pcSel4, ifidEn4, ifidFlush4, idexEn4, idexFlush4,
                      exmemEn4, exmemFlush4, memwbEn4, memwbFlush4};

    // Free-running clock with a 10-unit period
    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rstN),
        .ihit_i(ihit), .dhit_i(dhit), .mem_req_i(memReq),
        .mem_redirect_i(memRedirect), .mem_halt_i(memHalt),
        .idex_dren_i(idexDren), .idex_rt_i(idexRt),
        .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt),
        .pc_en_o(pcEn), .pc_sel_o(pcSel),
        .ifid_en_o(ifidEn), .ifid_flush_o(ifidFlush),
        .idex_en_o(idexEn), .idex_flush_o(idexFlush),
        .exmem_en_o(exmemEn), .exmem_flush_o(exmemFlush),
        .memwb_en_o(memwbEn), .memwb_flush_o(memwbFlush),
        .halt_o(haltOut), .stall_cnt_o(stallCnt)
    );

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rstN),
        .ihit_i(ihit), .dhit_i(dhit), .mem_req_i(memReq),
        .mem_redirect_i(memRedirect), .mem_halt_i(memHalt),
        .idex_dren_i(idexDren), .idex_rt_i(idexRt),
        .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt),
        .pc_en_o(pcEn4), .pc_sel_o(pcSel4),
        .ifid_en_o(ifidEn4), .ifid_flush_o(ifidFlush4),
        .idex_en_o(idexEn4), .idex_flush_o(idexFlush4),
        .exmem_en_o(exmemEn4), .exmem_flush_o(exmemFlush4),
        .memwb_en_o(memwbEn4), .memwb_flush_o(memwbFlush4),
        .halt_o(haltOut4), .stall_cnt_o(stallCnt4)
    );

    // Pop the oldest expectation and compare it against both instances
    task automatic checkOutput();
        exp_t  e;
        string tag;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
            return;
        end
        e   = expQ.pop_front();
        tag = tagQ.pop_front();
        checks++;
        assert (obsCtl === e.ctl) else begin
            errors++;
            $error("[TB] FAIL %s ctl: observed %b expected %b", tag, obsCtl, e.ctl);
        end
        checks++;
        assert (haltOut === e.halt) else begin
            errors++;
            $error("[TB] FAIL %s halt: observed %b expected %b", tag, haltOut, e.halt);
        end
        checks++;
        assert (stallCnt === e.cnt) else begin
            errors++;
            $error("[TB] FAIL %s stall_cnt: observed %0d expected %0d", tag, stallCnt, e.cnt);
        end
        checks++;
        assert (obsCtl4 === e.ctl) else begin
            errors++;
            $error("[TB] FAIL %s ctl4: observed %b expected %b", tag, obsCtl4, e.ctl);
        end
        checks++;
        assert (stallCnt4 === e.cnt4) else begin
            errors++;
            $error("[TB] FAIL %s stall_cnt4: observed %0d expected %0d", tag, stallCnt4, e.cnt4);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, check mid-cycle, then track the counters
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic ih, input logic dh, input logic mr,
                                 input logic rd, input logic hl, input logic dr,
                                 input logic [4:0] rt, input logic [4:0] rs,
                                 input logic [4:0] rtSrc,
                                 input logic [9:0] expCtl, input logic expHalt);
        exp_t e;
        rstN        = rst;
        ihit        = ih;
        dhit        = dh;
        memReq      = mr;
        memRedirect = rd;
        memHalt     = hl;
        idexDren    = dr;
        idexRt      = rt;
        ifidRs      = rs;
        ifidRt      = rtSrc;
        e.ctl  = expCtl;
        e.halt = expHalt;
        e.cnt  = rst ? expCnt  : 16'd0;
        e.cnt4 = rst ? expCnt4 : 4'd0;
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(negedge clk);
        checkOutput();
        if (!rst) begin
            expCnt  = '0;
            expCnt4 = '0;
        end else if (!expCtl[9] && !expHalt) begin
            if (expCnt  != 16'hFFFF) expCnt  = expCnt + 16'd1;
            if (expCnt4 != 4'hF)     expCnt4 = expCnt4 + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Directed sequence covering reset, hazards, dcache wait, redirect, halt and saturation
    initial begin
        rstN = 1'b0; ihit = 1'b1; dhit = 1'b0; memReq = 1'b0; memRedirect = 1'b0;
        memHalt = 1'b0; idexDren = 1'b0; idexRt = '0; ifidRs = '0; ifidRt = '0;
        @(posedge clk);
        #1;

        // reset holds every control low
        applyStimulus("reset0", 0, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("reset1", 0, 1,1,1,1,1,1, 5'd5,5'd5,5'd5, ZERO, 0);

        // idle running pipe
        for (int i = 0; i < 10; i++)
            applyStimulus("idle", 1, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ALL_EN, 0);

        // load-use on rs, then rt=0 is no hazard, then load-use on rt with icache miss
        applyStimulus("loaduse_rs", 1, 1,0,0,0,0,1, 5'd5,5'd5,5'd2, LOADUSE, 0);
        applyStimulus("after_lu",   1, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ALL_EN, 0);
        applyStimulus("rt_zero",    1, 1,0,0,0,0,1, 5'd0,5'd0,5'd0, ALL_EN, 0);
        applyStimulus("lu_rt_miss", 1, 0,0,0,0,0,1, 5'd7,5'd3,5'd7, LOADUSE, 0);
        applyStimulus("lu_nomatch", 1, 1,0,0,0,0,1, 5'd7,5'd3,5'd4, ALL_EN, 0);
        applyStimulus("imiss",      1, 0,0,0,0,0,0, 5'd0,5'd0,5'd0, NOIHIT, 0);

        // dcache miss for three cycles, completion decodes as RUN
        applyStimulus("dwait0", 1, 1,0,1,0,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("dwait1", 1, 1,0,1,0,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("dwait2", 1, 1,0,0,1,1,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("dhit",   1, 1,1,1,0,0,0, 5'd0,5'd0,5'd0, ALL_EN, 0);
        applyStimulus("postdw", 1, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ALL_EN, 0);
        applyStimulus("dwait3", 1, 1,0,1,0,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("dhit_im",1, 0,1,0,0,0,0, 5'd0,5'd0,5'd0, NOIHIT, 0);

        // redirect beats load-use and icache miss; dcache miss beats redirect
        applyStimulus("redirect",  1, 0,0,0,1,0,1, 5'd5,5'd5,5'd5, REDIRECT, 0);
        applyStimulus("dmiss_rd",  1, 1,0,1,1,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("dhit_rd",   1, 1,1,0,1,0,0, 5'd0,5'd0,5'd0, REDIRECT, 0);

        // reset during DWAIT returns straight to RUN
        applyStimulus("dwait_rst0", 1, 1,0,1,0,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("dwait_rst1", 0, 1,0,1,0,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("dwait_rst2", 1, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ALL_EN, 0);

        // halt: flush, drain, then sticky halted under random inputs
        applyStimulus("halt_fl", 1, 1,0,0,1,1,1, 5'd5,5'd5,5'd5, HALTFL, 0);
        applyStimulus("drain",   1, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, HALTFL, 0);
        for (int i = 0; i < 20; i++)
            applyStimulus("halted", 1, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                          1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                          1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                          5'($urandom_range(0,31)), 5'($urandom_range(0,31)),
                          5'($urandom_range(0,31)), ZERO, 1);
        applyStimulus("halt_rst", 0, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("run_again",1, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ALL_EN, 0);

        // reset during DRAIN gives no residual flush
        applyStimulus("drain_h", 1, 1,0,0,0,1,0, 5'd0,5'd0,5'd0, HALTFL, 0);
        applyStimulus("drain_r", 0, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ZERO, 0);
        applyStimulus("drain_x", 1, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ALL_EN, 0);

        // long icache miss saturates the 4-bit counter at 15
        for (int i = 0; i < 20; i++)
            applyStimulus("sat", 1, 0,0,0,0,0,0, 5'd0,5'd0,5'd0, NOIHIT, 0);
        applyStimulus("sat_end", 1, 1,0,0,0,0,0, 5'd0,5'd0,5'd0, ALL_EN, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
